// File: rtl/fp32_norm_stage.sv
// fp32_norm_stage: two-stage normalizer feeding the FPU rounding stage.
// Stage 1 brings the unit bit to position 46 and adjusts the exponent.
// Stage 2 handles the subnormal denormalizing shift, exponent range flags
// and extraction of the mantissa/round/sticky fields for rounding.
module fp32_norm_stage #(
  parameter int TAG_W     = 8,
  parameter int SHIFT_CAP = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [9:0]       in_exp,
  input  logic [47:0]      in_mant,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [7:0]       out_exp,
  output logic [23:0]      out_mant,
  output logic             out_round,
  output logic             out_sticky,
  output logic             out_ovf,
  output logic             out_tiny,
  output logic [2:0]       out_rm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SH_W = $clog2(SHIFT_CAP + 1);

  // stage 1 pipeline registers
  logic                s1_valid;
  logic [46:0]         s1_sig;
  logic signed [10:0]  s1_exp;
  logic                s1_lost;
  logic                s1_zero;
  logic                s1_sign;
  logic [2:0]          s1_rm;
  logic [TAG_W-1:0]    s1_tag;

  logic s1_adv;
  logic s2_adv;

  // stage 1 combinational results
  logic [5:0]          lz;
  logic signed [10:0]  e_ext;
  logic [46:0]         s1_sig_d;
  logic signed [10:0]  s1_exp_d;
  logic                s1_lost_d;
  logic                s1_zero_d;

  // stage 2 combinational results
  logic signed [10:0]        sh_raw;
  logic [SH_W-1:0]           sh;
  logic [46+SHIFT_CAP:0]     wide;
  logic [46:0]               sig_sh;
  logic                      sub_sticky;
  logic [7:0]                exp_d;
  logic [23:0]               mant_d;
  logic                      round_d;
  logic                      sticky_d;
  logic                      ovf_d;
  logic                      tiny_d;

  // Each stage moves when its downstream slot is free or being emptied.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: leading-zero count and normalizing shift of the raw significand.
  always_comb begin
    lz = '0;
    for (int i = 0; i < 47; i++) begin
      if (in_mant[i]) lz = 6'(46 - i);
    end
    e_ext     = signed'({in_exp[9], in_exp});
    s1_sig_d  = '0;
    s1_exp_d  = '0;
    s1_lost_d = 1'b0;
    s1_zero_d = 1'b0;
    if (in_mant[47]) begin
      s1_sig_d  = in_mant[47:1];
      s1_exp_d  = e_ext + 11'sd1;
      s1_lost_d = in_mant[0];
    end else if (|in_mant[46:0]) begin
      s1_sig_d = in_mant[46:0] << lz;
      s1_exp_d = e_ext - signed'({5'b0, lz});
    end else begin
      s1_zero_d = 1'b1;
    end
  end

  // Stage 1 register: capture the normalized operation on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sig   <= '0;
      s1_exp   <= '0;
      s1_lost  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_sign  <= 1'b0;
      s1_rm    <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sig  <= s1_sig_d;
        s1_exp  <= s1_exp_d;
        s1_lost <= s1_lost_d;
        s1_zero <= s1_zero_d;
        s1_sign <= in_sign;
        s1_rm   <= in_rm;
        s1_tag  <= in_tag;
      end
    end
  end

  // Stage 2: subnormal shift (capped, since beyond the cap everything lands
  // in sticky anyway), range classification and field extraction.
  always_comb begin
    sh_raw = 11'sd1 - s1_exp;
    sh     = '0;
    if (!s1_zero && s1_exp <= 11'sd0) begin
      if (sh_raw > signed'(11'(SHIFT_CAP))) sh = SH_W'(SHIFT_CAP);
      else                                  sh = sh_raw[SH_W-1:0];
    end
    wide       = {s1_sig, {SHIFT_CAP{1'b0}}} >> sh;
    sig_sh     = wide[46+SHIFT_CAP -: 47];
    sub_sticky = |wide[SHIFT_CAP-1:0];

    exp_d    = '0;
    mant_d   = '0;
    round_d  = 1'b0;
    sticky_d = 1'b0;
    ovf_d    = 1'b0;
    tiny_d   = 1'b0;
    if (!s1_zero) begin
      mant_d   = sig_sh[46:23];
      round_d  = sig_sh[22];
      sticky_d = (|sig_sh[21:0]) | s1_lost | sub_sticky;
      if (s1_exp <= 11'sd0) begin
        tiny_d = 1'b1;
      end else if (s1_exp >= 11'sd255) begin
        ovf_d = 1'b1;
        exp_d = 8'hFF;
      end else begin
        exp_d = s1_exp[7:0];
      end
    end
  end

  // Output register: loads from stage 1 when free, holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sign   <= 1'b0;
      out_exp    <= '0;
      out_mant   <= '0;
      out_round  <= 1'b0;
      out_sticky <= 1'b0;
      out_ovf    <= 1'b0;
      out_tiny   <= 1'b0;
      out_rm     <= '0;
      out_tag    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sign   <= s1_sign;
        out_exp    <= exp_d;
        out_mant   <= mant_d;
        out_round  <= round_d;
        out_sticky <= sticky_d;
        out_ovf    <= ovf_d;
        out_tiny   <= tiny_d;
        out_rm     <= s1_rm;
        out_tag    <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp32_norm_stage.sv
// Bench for fp32_norm_stage: directed vectors, backpressure, reset while
// stalled and a random run with random downstream readiness.
module tb_fp32_norm_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_mant = '0;
  logic [2:0]  in_rm = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [23:0] out_mant;
  logic        out_round;
  logic        out_sticky;
  logic        out_ovf;
  logic        out_tiny;
  logic [2:0]  out_rm;
  logic [7:0]  out_tag;

  int n_checks = 0;
  int n_errors = 0;
  int ready_mode = 0;
  logic [47:0] sb[$];

  fp32_norm_stage #(.TAG_W(8), .SHIFT_CAP(26)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
    .out_round(out_round), .out_sticky(out_sticky),
    .out_ovf(out_ovf), .out_tiny(out_tiny),
    .out_rm(out_rm), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [47:0] pk(input logic s, input logic [7:0] e, input logic [23:0] m,
                                     input logic r, input logic st, input logic ov, input logic ti,
                                     input logic [2:0] rm, input logic [7:0] tg);
    return {1'b0, s, e, m, r, st, ov, ti, rm, tg};
  endfunction

  function automatic logic [47:0] dut_pk();
    return pk(out_sign, out_exp, out_mant, out_round, out_sticky, out_ovf, out_tiny, out_rm, out_tag);
  endfunction

  // Reference: locate the MSB, place it at bit 46, then denormalize bit by bit.
  function automatic logic [47:0] model(input logic s, input logic [9:0] e, input logic [47:0] m,
                                        input logic [2:0] rm, input logic [7:0] tg);
    int p = -1;
    int en;
    int sh;
    logic [47:0] v;
    logic st = 1'b0;
    logic [7:0] ex;
    logic ov = 1'b0;
    logic ti = 1'b0;
    for (int i = 0; i < 48; i++) if (m[i]) p = i;
    if (p < 0) return pk(s, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0, rm, tg);
    en = int'($signed(e)) + p - 46;
    v = m;
    if (p == 47) begin
      st = v[0];
      v = v >> 1;
    end else begin
      v = v << (46 - p);
    end
    if (en <= 0) begin
      sh = 1 - en;
      if (sh > 26) sh = 26;
      for (int k = 0; k < sh; k++) begin
        st = st | v[0];
        v = v >> 1;
      end
    end
    st = st | (|v[21:0]);
    if (en <= 0) begin
      ex = 8'd0; ti = 1'b1;
    end else if (en >= 255) begin
      ex = 8'hFF; ov = 1'b1;
    end else begin
      ex = 8'(en);
    end
    return pk(s, ex, v[46:23], v[22], st, ov, ti, rm, tg);
  endfunction

  // Downstream readiness: 0 low, 1 high, 2 random.
  always begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: scoreboard compare on transfer, stability while stalled.
  logic        prev_stall = 1'b0;
  logic [47:0] snap = '0;
  logic [47:0] exp_item;
  always @(negedge clk) begin
    if (prev_stall && out_valid) check("stable", dut_pk(), snap);
    prev_stall = rst_n && out_valid && !out_ready;
    snap = dut_pk();
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", {47'd0, out_valid}, 48'd0);
      end else begin
        exp_item = sb.pop_front();
        check("result", dut_pk(), exp_item);
      end
    end
  end

  task automatic set_ready(input int m);
    ready_mode = m;
    @(posedge clk); #2;
  endtask

  // Called after a posedge; returns at posedge+1 after the accepting edge.
  task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m,
                      input logic [2:0] rm, input logic [7:0] tg,
                      input logic [47:0] expv, input bit push);
    logic ok = 1'b0;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_rm = rm; in_tag = tg;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (push) sb.push_back(expv);
        break;
      end
    end
    check("send_timeout", {47'd0, ok}, 48'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_m(input logic s, input logic [9:0] e, input logic [47:0] m,
                        input logic [2:0] rm, input logic [7:0] tg);
    send(s, e, m, rm, tg, model(s, e, m, rm, tg), 1'b1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    check("drain", 48'(sb.size()), 48'd0);
  endtask

  initial begin
    logic [47:0] m;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {47'd0, out_valid}, 48'd0);
    check("rst_outputs", dut_pk(), 48'd0);
    check("rst_in_ready", {47'd0, in_ready}, 48'd1);
    set_ready(1);

    // First op also checks the two-cycle latency.
    send(1'b0, 10'd127, 48'd1 << 46, 3'd0, 8'd1,
         pk(1'b0, 8'd127, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1), 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge_n", {47'd0, out_valid}, 48'd0);
    @(negedge clk);
    check("lat_edge_n1", {47'd0, out_valid}, 48'd1);
    @(posedge clk); #1;

    // Directed vectors, back to back.
    send(1'b0, 10'd127, (48'd1 << 47) | 48'd1, 3'd1, 8'd2,
         pk(1'b0, 8'd128, 24'h800000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'd2), 1'b1);
    send(1'b1, 10'd127, 48'd1 << 40, 3'd2, 8'd3,
         pk(1'b1, 8'd121, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd3), 1'b1);
    send(1'b0, 10'(-2), 48'd1 << 46, 3'd3, 8'd4,
         pk(1'b0, 8'd0, 24'h100000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'd4), 1'b1);
    send(1'b0, 10'(-100), 48'd1 << 46, 3'd4, 8'd5,
         pk(1'b0, 8'd0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 8'd5), 1'b1);
    send(1'b0, 10'd300, 48'd1 << 46, 3'd0, 8'd6,
         pk(1'b0, 8'hFF, 24'h800000, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd6), 1'b1);
    send(1'b1, 10'd50, 48'd0, 3'd7, 8'hA5,
         pk(1'b1, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 8'hA5), 1'b1);
    // Round bit set, exponent 255 boundary, and En=0 (shift by one) boundary.
    send(1'b0, 10'd254, (48'd1 << 46) | (48'd1 << 22), 3'd0, 8'd7,
         pk(1'b0, 8'd254, 24'h800000, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd7), 1'b1);
    send_m(1'b0, 10'd255, 48'h4000_0000_0003, 3'd1, 8'd8);
    send_m(1'b1, 10'd0, 48'h7FFF_FFFF_FFFF, 3'd2, 8'd9);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: only two ops fit while downstream is stalled.
    set_ready(0);
    send_m(1'b0, 10'd100, 48'h0000_1234_5678, 3'd1, 8'd1);
    send_m(1'b1, 10'd10, 48'hC000_0000_0001, 3'd2, 8'd2);
    in_valid = 1'b1; in_tag = 8'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", {47'd0, in_ready}, 48'd0);
      @(posedge clk); #1;
    end
    ready_mode = 1;
    send_m(1'b0, 10'd127, 48'h0000_0000_0001, 3'd3, 8'd3);
    send_m(1'b1, 10'(-20), 48'h0012_3456_789A, 3'd4, 8'd4);
    in_valid = 1'b0;
    wait_drain();

    // Reset while two ops are held; they must never appear.
    set_ready(0);
    send(1'b1, 10'd127, 48'd1 << 46, 3'd5, 8'hEE, 48'd0, 1'b0);
    send(1'b1, 10'd127, 48'd1 << 45, 3'd6, 8'hEF, 48'd0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_stall_valid", {47'd0, out_valid}, 48'd0);
    check("rst_stall_outputs", dut_pk(), 48'd0);
    check("rst_stall_in_ready", {47'd0, in_ready}, 48'd1);
    set_ready(1);
    repeat (5) @(posedge clk);
    #1;
    send_m(1'b0, 10'd130, 48'h0000_8000_0000, 3'd1, 8'h42);
    in_valid = 1'b0;
    wait_drain();

    // Random run with random downstream readiness.
    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      m = {16'($urandom), $urandom};
      m = m >> $urandom_range(0, 48);
      send_m(1'($urandom), 10'($urandom_range(0, 400) - 60), m,
             3'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    set_ready(1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
